// File: rtl/signature_dumper.sv
// signature_dumper: snoops signature control stores and streams DCatch words [begin,end) out.
// Optional watchdog-started dump with `define SIG_TIMEOUT_EN. Rev 1.0
`default_nettype none

module signature_dumper #(
  parameter logic [31:0] SIG_BASE    = 32'h1000_0000,
  parameter logic [31:0] DC_BASE     = 32'h0000_1000,
  parameter int          DC_AW       = 11,
  parameter int          TIMEOUT_CYC = 10240
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             snp_we,
  input  logic [31:0]      snp_addr,
  input  logic [31:0]      snp_wdata,
  output logic             rd_en,
  output logic [DC_AW-1:0] rd_addr,
  input  logic [31:0]      rd_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic             out_last,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             timed_out
);

  localparam logic [2:0] c_S_IDLE  = 3'd0;
  localparam logic [2:0] c_S_CHECK = 3'd1;
  localparam logic [2:0] c_S_READ  = 3'd2;
  localparam logic [2:0] c_S_WAIT  = 3'd3;
  localparam logic [2:0] c_S_SEND  = 3'd4;
  localparam logic [2:0] c_S_DONE  = 3'd5;
  localparam logic [2:0] c_S_ERR   = 3'd6;

  localparam logic [31:0] c_DC_END    = DC_BASE + (32'd4 << DC_AW);
  localparam logic [31:0] c_ADDR_BEG  = SIG_BASE + 32'h8;
  localparam logic [31:0] c_ADDR_END  = SIG_BASE + 32'hC;
  localparam logic [31:0] c_ADDR_FLAG = SIG_BASE + 32'h10;

  logic [2:0]  r_state;
  logic [31:0] r_beg;
  logic [31:0] r_end;
  logic [31:0] r_ptr;
  logic        r_out_valid;
  logic [31:0] r_out_data;
  logic        r_out_last;
  logic        r_done;
  logic        r_err;
  logic        r_timed_out;

  logic        w_idle;
  logic        w_flag;
  logic        w_start;
  logic        w_range_bad;
  logic [31:0] w_ptr_off;
  logic [31:0] w_ptr_next;
  logic [DC_AW+1:0] w_unused_bits;

  assign w_idle     = (r_state == c_S_IDLE);
  assign w_flag     = snp_we && (snp_addr == c_ADDR_FLAG) && (snp_wdata == 32'd1);
  assign w_ptr_off  = r_ptr - DC_BASE;
  assign w_ptr_next = r_ptr + 32'd4;

  assign w_range_bad = (r_beg[1:0] != 2'b00) || (r_end[1:0] != 2'b00) ||
                       (r_beg < DC_BASE) || (r_end > c_DC_END);

`ifdef SIG_TIMEOUT_EN
  localparam int c_WDOG_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [c_WDOG_W-1:0] c_WDOG_LAST = c_WDOG_W'(TIMEOUT_CYC - 1);

  logic [c_WDOG_W-1:0] r_wdog;
  logic                w_wdog_fire;

  // A genuine flag in the same cycle wins; the watchdog only fires when nothing started the dump.
  assign w_wdog_fire = w_idle && !w_flag && (r_wdog == c_WDOG_LAST);
  assign w_start     = w_flag || w_wdog_fire;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wdog      <= '0;
      r_timed_out <= 1'b0;
    end else if (w_idle) begin
      if (w_wdog_fire) begin
        r_timed_out <= 1'b1;
      end else begin
        r_wdog <= r_wdog + 1'b1;
      end
    end
  end
`else
  logic [31:0] w_unused_cfg;

  assign w_unused_cfg = TIMEOUT_CYC;
  assign w_start      = w_flag;

  always_ff @(posedge clk) begin
    r_timed_out <= 1'b0;
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= c_S_IDLE;
      r_beg       <= '0;
      r_end       <= '0;
      r_ptr       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      case (r_state)
        c_S_IDLE: begin
          if (snp_we && (snp_addr == c_ADDR_BEG)) r_beg <= snp_wdata;
          if (snp_we && (snp_addr == c_ADDR_END)) r_end <= snp_wdata;
          if (w_start) r_state <= c_S_CHECK;
        end
        c_S_CHECK: begin
          if (w_range_bad) begin
            r_err   <= 1'b1;
            r_state <= c_S_ERR;
          end else if (r_end <= r_beg) begin
            r_done  <= 1'b1;
            r_state <= c_S_DONE;
          end else begin
            r_ptr   <= r_beg;
            r_state <= c_S_READ;
          end
        end
        c_S_READ: begin
          r_state <= c_S_WAIT;
        end
        c_S_WAIT: begin
          r_out_data  <= rd_data;
          r_out_valid <= 1'b1;
          r_out_last  <= (w_ptr_next == r_end);
          r_state     <= c_S_SEND;
        end
        c_S_SEND: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            if (r_out_last) begin
              r_done  <= 1'b1;
              r_state <= c_S_DONE;
            end else begin
              r_ptr   <= w_ptr_next;
              r_state <= c_S_READ;
            end
          end
        end
        c_S_DONE: r_state <= c_S_DONE;
        c_S_ERR:  r_state <= c_S_ERR;
        default:  r_state <= c_S_IDLE;
      endcase
    end
  end

  // Word index is only driven while reading so the address bus stays 0 otherwise.
  assign rd_en         = (r_state == c_S_READ);
  assign rd_addr       = rd_en ? w_ptr_off[DC_AW+1:2] : '0;
  assign w_unused_bits = {w_ptr_off[31:DC_AW+2], w_ptr_off[1:0]};

  assign busy      = (r_state == c_S_READ) || (r_state == c_S_WAIT) || (r_state == c_S_SEND);
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;
  assign done      = r_done;
  assign err       = r_err;
  assign timed_out = r_timed_out;

endmodule

`default_nettype wire

// File: tb/tb_signature_dumper.sv
// tb_signature_dumper: vector table plus directed sequences for signature_dumper.
`default_nettype none

module tb_signature_dumper;

  localparam logic [31:0] SIG = 32'h1000_0000;
  localparam int AW = 11;
`ifdef SIG_TIMEOUT_EN
  localparam int TO = 64;
`else
  localparam int TO = 10240;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          snp_we = 1'b0;
  logic [31:0]   snp_addr = '0;
  logic [31:0]   snp_wdata = '0;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [31:0]   rd_data = '0;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_data;
  logic          out_last;
  logic          busy;
  logic          done;
  logic          err;
  logic          timed_out;

  int checks = 0;
  int errors = 0;

  signature_dumper #(.TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .snp_we(snp_we), .snp_addr(snp_addr), .snp_wdata(snp_wdata),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .done(done), .err(err), .timed_out(timed_out)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] pat(input int idx);
    return 32'hA500_0000 | 32'(idx);
  endfunction

  // DCatch model: registered read, data valid the clock after rd_en.
  always @(posedge clk) if (rd_en) rd_data <= pat(int'(rd_addr));

  int unsigned cyc = 0;
  logic ready_mode = 1'b0;
  always @(posedge clk) cyc <= cyc + 1;
  assign out_ready = ready_mode ? ((cyc % 3) == 0) : 1'b1;

  logic [31:0] q_data[$];
  logic        q_last[$];
  int          rd_cnt = 0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data = '0;
  logic        prev_last = 1'b0;

  always @(negedge clk) begin
    if (prev_stall) begin
      checks++;
      if (!out_valid || out_data !== prev_data || out_last !== prev_last) begin
        errors++;
        $display("FAIL hold_stable got v=%b d=%h l=%b exp v=1 d=%h l=%b",
                 out_valid, out_data, out_last, prev_data, prev_last);
      end
    end
    prev_stall = out_valid && !out_ready;
    prev_data  = out_data;
    prev_last  = out_last;
    if (out_valid && out_ready) begin
      q_data.push_back(out_data);
      q_last.push_back(out_last);
    end
    if (rd_en) rd_cnt++;
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    snp_we = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    q_data.delete();
    q_last.delete();
    rd_cnt = 0;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    snp_we = 1'b1;
    snp_addr = a;
    snp_wdata = d;
    tick();
    snp_we = 1'b0;
  endtask

  task automatic wait_end(input int budget);
    int n;
    n = 0;
    while (!(done || err) && n < budget) begin
      tick();
      n++;
    end
    chk("end_wait", {31'd0, done || err}, 32'd1);
  endtask

  task automatic check_dump(input string nm, input logic [31:0] beg, input int n);
    int base;
    base = int'((beg - 32'h1000) >> 2);
    chk({nm, "_nwords"}, q_data.size(), n);
    chk({nm, "_rdcnt"}, rd_cnt, n);
    for (int k = 0; k < n && k < q_data.size(); k++) begin
      chk($sformatf("%s_data%0d", nm, k), q_data[k], pat(base + k));
      chk($sformatf("%s_last%0d", nm, k), {31'd0, q_last[k]}, {31'd0, k == n - 1});
    end
  endtask

  task automatic chk_quiet(input string nm);
    chk({nm, "_rd_en"}, {31'd0, rd_en}, 0);
    chk({nm, "_rd_addr"}, {21'd0, rd_addr}, 0);
    chk({nm, "_valid"}, {31'd0, out_valid}, 0);
    chk({nm, "_data"}, out_data, 0);
    chk({nm, "_last"}, {31'd0, out_last}, 0);
    chk({nm, "_busy"}, {31'd0, busy}, 0);
    chk({nm, "_flags"}, {29'd0, done, err, timed_out}, 0);
  endtask

  typedef struct {
    logic [31:0] beg;
    logic [31:0] endw;
    logic        rmode;
    logic        exp_err;
    int          exp_n;
  } vec_t;

  vec_t vt[10];

  initial begin
    vt[0] = '{32'h2000, 32'h2010, 1'b0, 1'b0, 4};
    vt[1] = '{32'h2000, 32'h2010, 1'b1, 1'b0, 4};
    vt[2] = '{32'h2000, 32'h2000, 1'b0, 1'b0, 0};
    vt[3] = '{32'h2002, 32'h2010, 1'b0, 1'b1, 0};
    vt[4] = '{32'h2000, 32'h200E, 1'b0, 1'b1, 0};
    vt[5] = '{32'h0FFC, 32'h1008, 1'b0, 1'b1, 0};
    vt[6] = '{32'h1000, 32'h1008, 1'b1, 1'b0, 2};
    vt[7] = '{32'h2FF8, 32'h3000, 1'b0, 1'b0, 2};
    vt[8] = '{32'h2FF8, 32'h3004, 1'b0, 1'b1, 0};
    vt[9] = '{32'h2010, 32'h2000, 1'b0, 1'b0, 0};

    // Outputs while reset is held.
    rst = 1'b0;
    tick();
    tick();
    chk_quiet("reset");

    for (int i = 0; i < 10; i++) begin
      ready_mode = vt[i].rmode;
      do_reset();
      store(SIG + 32'h8, vt[i].beg);
      store(SIG + 32'hC, vt[i].endw);
      store(SIG + 32'h10, 32'd1);
      wait_end(300);
      chk($sformatf("v%0d_err", i), {31'd0, err}, {31'd0, vt[i].exp_err});
      chk($sformatf("v%0d_done", i), {31'd0, done}, {31'd0, !vt[i].exp_err});
      chk($sformatf("v%0d_idle", i), {29'd0, busy, out_valid, timed_out}, 0);
      check_dump($sformatf("v%0d", i), vt[i].beg, vt[i].exp_n);
    end
    ready_mode = 1'b0;

    // First rd_en lands two clocks after the flag store.
    do_reset();
    store(SIG + 32'h8, 32'h2000);
    store(SIG + 32'hC, 32'h2010);
    store(SIG + 32'h10, 32'd1);
    chk("lat_check_rd_en", {31'd0, rd_en}, 0);
    tick();
    chk("lat_read_rd_en", {31'd0, rd_en}, 1);
    chk("lat_read_addr", {21'd0, rd_addr}, 32'h400);
    chk("lat_read_busy", {31'd0, busy}, 1);
    wait_end(100);
    check_dump("lat", 32'h2000, 4);

    // Empty range: done exactly two clocks after the flag, never any word.
    do_reset();
    store(SIG + 32'h8, 32'h2000);
    store(SIG + 32'hC, 32'h2000);
    store(SIG + 32'h10, 32'd1);
    chk("empty_done_early", {31'd0, done}, 0);
    tick();
    chk("empty_done", {31'd0, done}, 1);
    chk("empty_rdcnt", rd_cnt, 0);

    // Non-1 flag ignored; snoops while busy ignored.
    do_reset();
    store(SIG + 32'h8, 32'h2000);
    store(SIG + 32'hC, 32'h2010);
    store(SIG + 32'h10, 32'd2);
    repeat (5) tick();
    chk("flag2_busy", {31'd0, busy}, 0);
    chk("flag2_done", {31'd0, done}, 0);
    chk("flag2_rdcnt", rd_cnt, 0);
    store(SIG + 32'h10, 32'd1);
    tick();
    store(SIG + 32'h8, 32'h2008);
    store(SIG + 32'h10, 32'd1);
    store(SIG + 32'hC, 32'h2004);
    wait_end(100);
    check_dump("busy_snoop", 32'h2000, 4);

    // Reset during the second word aborts; beg/end are cleared by it.
    begin
      int n;
      int r0;
      do_reset();
      store(SIG + 32'h8, 32'h2000);
      store(SIG + 32'hC, 32'h2010);
      store(SIG + 32'h10, 32'd1);
      n = 0;
      while (q_data.size() < 1 && n < 50) begin
        tick();
        n++;
      end
      chk("mid_first_word", q_data.size(), 1);
      chk("mid_in_read", {31'd0, rd_en}, 1);
      rst = 1'b0;
      tick();
      chk_quiet("mid_reset");
      r0 = rd_cnt;
      repeat (3) tick();
      chk("mid_no_rd", rd_cnt, r0);
      chk("mid_no_word", q_data.size(), 1);
      rst = 1'b1;
      store(SIG + 32'h10, 32'd1);
      wait_end(50);
      chk("mid_cleared_err", {31'd0, err}, 1);
      do_reset();
      store(SIG + 32'h8, 32'h2000);
      store(SIG + 32'hC, 32'h2010);
      store(SIG + 32'h10, 32'd1);
      wait_end(100);
      check_dump("restart", 32'h2000, 4);
    end

    // Watchdog behaviour.
    begin
      int n;
      do_reset();
      store(SIG + 32'h8, 32'h2000);
      store(SIG + 32'hC, 32'h2008);
`ifdef SIG_TIMEOUT_EN
      n = 2;
      while (!timed_out && n < 200) begin
        tick();
        n++;
      end
      chk("wdog_cycle", n, 64);
      wait_end(100);
      chk("wdog_done", {31'd0, done}, 1);
      chk("wdog_flag", {31'd0, timed_out}, 1);
      check_dump("wdog", 32'h2000, 2);
`else
      n = 0;
      repeat (1000) tick();
      chk("nowdog_rdcnt", rd_cnt, n);
      chk("nowdog_words", q_data.size(), 0);
      chk("nowdog_flags", {28'd0, busy, done, err, timed_out}, 0);
`endif
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "bench time limit");
  end

endmodule

`default_nettype wire
